vga_buffer_reader: RTL and testbench

Read side of the camera frame buffer: generates 640x480@60 VGA timing on the 25 MHz pixel clock and fetches the stored 160x96 RGB332 image from the synchronous dual-port frame RAM. Each stored pixel is scaled 4x4, so the image fills lines 0–383 and lines 384–479 show background. It sits between the frame RAM read port and the VGA connector, opposite the capture-side write-address counter.

---
 rtl/vga_pkg.sv | 49 ++++
 rtl/vga_timing.sv | 61 ++++++
 rtl/vga_buffer_reader.sv | 131 +++++++++++++
 tb/tb_vga_buffer_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: VGA 640x480@60 timing, stored image geometry and data widths
// shared by the frame buffer read side and the capture-side address counter.
package vga_pkg;

  // Horizontal timing in pixel clocks
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Vertical timing in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Stored image: 160x96 pixels, shown 4x4 upscaled
  localparam int IMG_W      = 160;
  localparam int IMG_H      = 96;
  localparam int IMG_SIZE   = IMG_W * IMG_H;
  localparam int SCALE_LOG2 = 2;

  // Data path widths
  localparam int ADDR_W  = 15;
  localparam int PIX_W   = 8;
  localparam int H_CNT_W = 10;
  localparam int V_CNT_W = 10;

  // Colours driven when no stored pixel is shown
  localparam logic [PIX_W-1:0] BG_COLOR    = 8'h00;
  localparam logic [PIX_W-1:0] BLANK_COLOR = 8'h00;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PIX_W-1:0]  pixel_t;

  // Control bits that travel down the pipeline alongside the pixel address
  typedef struct packed {
    logic in_img;
    logic active;
    logic hsync_n;
    logic vsync_n;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RESET = '{in_img: 1'b0, active: 1'b0,
                                        hsync_n: 1'b1, vsync_n: 1'b1};

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running pixel/line counters with raw (undelayed) sync
// levels and the visible-area flag. Geometry defaults to 640x480@60.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACT      = H_ACTIVE,
  parameter int H_FP_LEN   = H_FP,
  parameter int H_SYNC_LEN = H_SYNC,
  parameter int H_BP_LEN   = H_BP,
  parameter int V_ACT      = V_ACTIVE,
  parameter int V_FP_LEN   = V_FP,
  parameter int V_SYNC_LEN = V_SYNC,
  parameter int V_BP_LEN   = V_BP
) (
  input  logic               pclk,
  input  logic               in_reset,
  output logic [H_CNT_W-1:0] hcount,
  output logic [V_CNT_W-1:0] vcount,
  output logic               line_end,
  output logic               frame_wrap,
  output logic               hsync_raw,
  output logic               vsync_raw,
  output logic               active
);

  localparam int H_TOT = H_ACT + H_FP_LEN + H_SYNC_LEN + H_BP_LEN;
  localparam int V_TOT = V_ACT + V_FP_LEN + V_SYNC_LEN + V_BP_LEN;

  localparam logic [H_CNT_W-1:0] H_LAST       = H_CNT_W'(H_TOT - 1);
  localparam logic [V_CNT_W-1:0] V_LAST       = V_CNT_W'(V_TOT - 1);
  localparam logic [H_CNT_W-1:0] H_VIS_END    = H_CNT_W'(H_ACT);
  localparam logic [V_CNT_W-1:0] V_VIS_END    = V_CNT_W'(V_ACT);
  localparam logic [H_CNT_W-1:0] H_SYNC_START = H_CNT_W'(H_ACT + H_FP_LEN);
  localparam logic [H_CNT_W-1:0] H_SYNC_END   = H_CNT_W'(H_ACT + H_FP_LEN + H_SYNC_LEN);
  localparam logic [V_CNT_W-1:0] V_SYNC_START = V_CNT_W'(V_ACT + V_FP_LEN);
  localparam logic [V_CNT_W-1:0] V_SYNC_END   = V_CNT_W'(V_ACT + V_FP_LEN + V_SYNC_LEN);

  assign line_end   = (hcount == H_LAST);
  assign frame_wrap = line_end && (vcount == V_LAST);

  // Pixel counter wraps every line; line counter steps at each line end and wraps per frame.
  always_ff @(posedge pclk or posedge in_reset) begin
    if (in_reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (line_end) begin
      hcount <= '0;
      vcount <= frame_wrap ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  // Sync pulses are active low; visible area is the top-left H_ACT x V_ACT window.
  always_comb begin
    hsync_raw = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
    vsync_raw = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
    active    = (hcount < H_VIS_END) && (vcount < V_VIS_END);
  end

endmodule

// File: rtl/vga_buffer_reader.sv
// vga_buffer_reader: reads the 160x96 RGB332 frame buffer and drives a
// 4x4-upscaled image onto VGA. Two-stage pipeline: stage 1 issues the RAM
// address, stage 2 registers the returned pixel together with the syncs.
module vga_buffer_reader
  import vga_pkg::*;
#(
  parameter int H_ACT      = H_ACTIVE,
  parameter int H_FP_LEN   = H_FP,
  parameter int H_SYNC_LEN = H_SYNC,
  parameter int H_BP_LEN   = H_BP,
  parameter int V_ACT      = V_ACTIVE,
  parameter int V_FP_LEN   = V_FP,
  parameter int V_SYNC_LEN = V_SYNC,
  parameter int V_BP_LEN   = V_BP,
  parameter int IMG_COLS   = IMG_W,
  parameter int IMG_ROWS   = IMG_H
) (
  input  logic              pclk,
  input  logic              in_reset,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_end
);

  // Image area in screen coordinates after upscaling
  localparam logic [H_CNT_W-1:0] IMG_X_END  = H_CNT_W'(IMG_COLS << SCALE_LOG2);
  localparam logic [V_CNT_W-1:0] IMG_Y_END  = V_CNT_W'(IMG_ROWS << SCALE_LOG2);
  localparam logic [H_CNT_W-1:0] IMG_X_LAST = H_CNT_W'((IMG_COLS << SCALE_LOG2) - 1);
  localparam logic [V_CNT_W-1:0] IMG_Y_LAST = V_CNT_W'((IMG_ROWS << SCALE_LOG2) - 1);
  localparam addr_t              ROW_STEP   = ADDR_W'(IMG_COLS);

  logic [H_CNT_W-1:0] hcount;
  logic [V_CNT_W-1:0] vcount;
  logic               line_end;
  logic               frame_wrap;
  logic               hsync_raw;
  logic               vsync_raw;
  logic               active;

  addr_t      row_base;
  addr_t      x_img;
  logic       in_img0;
  logic       row_done;
  logic       last_pix0;
  pipe_ctrl_t ctrl0;
  pipe_ctrl_t ctrl1;
  pixel_t     rgb_next;

  vga_timing #(
    .H_ACT      (H_ACT),
    .H_FP_LEN   (H_FP_LEN),
    .H_SYNC_LEN (H_SYNC_LEN),
    .H_BP_LEN   (H_BP_LEN),
    .V_ACT      (V_ACT),
    .V_FP_LEN   (V_FP_LEN),
    .V_SYNC_LEN (V_SYNC_LEN),
    .V_BP_LEN   (V_BP_LEN)
  ) u_timing (
    .pclk       (pclk),
    .in_reset   (in_reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .line_end   (line_end),
    .frame_wrap (frame_wrap),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .active     (active)
  );

  // Stage 0: decode the counter position into image coordinates and control bits.
  always_comb begin
    in_img0       = (hcount < IMG_X_END) && (vcount < IMG_Y_END);
    x_img         = ADDR_W'(hcount >> SCALE_LOG2);
    row_done      = &vcount[SCALE_LOG2-1:0];
    last_pix0     = (hcount == IMG_X_LAST) && (vcount == IMG_Y_LAST);
    ctrl0         = CTRL_RESET;
    ctrl0.in_img  = in_img0;
    ctrl0.active  = active;
    ctrl0.hsync_n = hsync_raw;
    ctrl0.vsync_n = vsync_raw;
  end

  // Running y_img*IMG_COLS: step once per group of scaled lines, stop after the last image row.
  always_ff @(posedge pclk or posedge in_reset) begin
    if (in_reset) begin
      row_base <= '0;
    end else if (frame_wrap) begin
      row_base <= '0;
    end else if (line_end && row_done && (vcount < IMG_Y_LAST)) begin
      row_base <= row_base + ROW_STEP;
    end
  end

  // Stage 1: issue the RAM address; frame_end marks the cycle the final image address is issued.
  always_ff @(posedge pclk or posedge in_reset) begin
    if (in_reset) begin
      rd_addr   <= '0;
      ctrl1     <= CTRL_RESET;
      frame_end <= 1'b0;
    end else begin
      rd_addr   <= in_img0 ? (row_base + x_img) : '0;
      ctrl1     <= ctrl0;
      frame_end <= last_pix0;
    end
  end

  // Stage 2 colour select: RAM data inside the image, background elsewhere, black in blanking.
  always_comb begin
    rgb_next = BLANK_COLOR;
    if (ctrl1.active) begin
      rgb_next = ctrl1.in_img ? rd_data : BG_COLOR;
    end
  end

  // Stage 2: register colour and syncs together so all three reach the DAC aligned.
  always_ff @(posedge pclk or posedge in_reset) begin
    if (in_reset) begin
      rgb   <= BLANK_COLOR;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb   <= rgb_next;
      hsync <= ctrl1.hsync_n;
      vsync <= ctrl1.vsync_n;
    end
  end

endmodule

// File: tb/tb_vga_buffer_reader.sv
// tb_vga_buffer_reader: checks the buffer reader against a position-based
// model of the VGA raster. A full-size instance covers the first lines of a
// 640x480 frame; a reduced-geometry instance covers whole frames, blanking
// and mid-frame reset within a short run.
module tb_vga_buffer_reader;
  import vga_pkg::*;

  typedef struct packed {
    int h_act; int h_fp; int h_sync; int h_tot;
    int v_act; int v_fp; int v_sync; int v_tot;
    int cols;  int rows;
  } geom_t;

  localparam geom_t G_FULL  = '{h_act: 640, h_fp: 16, h_sync: 96, h_tot: 800,
                                v_act: 480, v_fp: 10, v_sync: 2, v_tot: 525,
                                cols: 160, rows: 96};
  localparam geom_t G_SMALL = '{h_act: 64, h_fp: 4, h_sync: 8, h_tot: 80,
                                v_act: 48, v_fp: 2, v_sync: 2, v_tot: 55,
                                cols: 16, rows: 8};

  logic pclk = 1'b0;
  logic rst_full;
  logic rst_small;
  logic force_ff;

  logic [7:0] mem [0:IMG_SIZE-1];

  logic [ADDR_W-1:0] rd_addr_f, rd_addr_s;
  logic [7:0]        rd_data_f, rd_data_s, rgb_f, rgb_s;
  logic              hsync_f, vsync_f, frame_end_f;
  logic              hsync_s, vsync_s, frame_end_s;

  int vectors     = 0;
  int miscompares = 0;

  always #20 pclk = ~pclk;

  // Frame RAM model: data for an address is available by the following edge
  assign rd_data_f = force_ff ? 8'hFF : mem[rd_addr_f];
  assign rd_data_s = force_ff ? 8'hFF : mem[rd_addr_s];

  vga_buffer_reader dut_full (
    .pclk(pclk), .in_reset(rst_full), .rd_addr(rd_addr_f), .rd_data(rd_data_f),
    .rgb(rgb_f), .hsync(hsync_f), .vsync(vsync_f), .frame_end(frame_end_f)
  );

  vga_buffer_reader #(
    .H_ACT(64), .H_FP_LEN(4), .H_SYNC_LEN(8), .H_BP_LEN(4),
    .V_ACT(48), .V_FP_LEN(2), .V_SYNC_LEN(2), .V_BP_LEN(3),
    .IMG_COLS(16), .IMG_ROWS(8)
  ) dut_small (
    .pclk(pclk), .in_reset(rst_small), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .rgb(rgb_s), .hsync(hsync_s), .vsync(vsync_s), .frame_end(frame_end_s)
  );

  // Reference model: p is the raster position (pixel clocks since frame start)
  function automatic int m_h(geom_t g, int p); return p % g.h_tot; endfunction
  function automatic int m_v(geom_t g, int p); return (p / g.h_tot) % g.v_tot; endfunction

  function automatic bit m_in_img(geom_t g, int p);
    if (p < 0) return 1'b0;
    return (m_h(g, p) < g.cols * 4) && (m_v(g, p) < g.rows * 4);
  endfunction

  function automatic int m_addr(geom_t g, int p);
    if (!m_in_img(g, p)) return 0;
    return (m_v(g, p) / 4) * g.cols + m_h(g, p) / 4;
  endfunction

  function automatic logic [7:0] m_rgb(geom_t g, int p, bit ff);
    if (p < 0) return 8'h00;
    if (m_h(g, p) >= g.h_act || m_v(g, p) >= g.v_act) return 8'h00;
    if (!m_in_img(g, p)) return BG_COLOR;
    return ff ? 8'hFF : mem[m_addr(g, p)];
  endfunction

  function automatic logic m_hsync(geom_t g, int p);
    if (p < 0) return 1'b1;
    return !(m_h(g, p) >= g.h_act + g.h_fp && m_h(g, p) < g.h_act + g.h_fp + g.h_sync);
  endfunction

  function automatic logic m_vsync(geom_t g, int p);
    if (p < 0) return 1'b1;
    return !(m_v(g, p) >= g.v_act + g.v_fp && m_v(g, p) < g.v_act + g.v_fp + g.v_sync);
  endfunction

  function automatic logic m_fend(geom_t g, int p);
    if (p < 0) return 1'b0;
    return (m_h(g, p) == g.cols * 4 - 1) && (m_v(g, p) == g.rows * 4 - 1);
  endfunction

  task automatic test_reset();
    #2;
    rst_full  = 1'b1;
    rst_small = 1'b1;
    #3;
    vectors++; if (rd_addr_f !== '0)     begin miscompares++; $display("[TB] FAIL reset_full_addr got=%0d exp=0", rd_addr_f); end
    vectors++; if (rgb_f !== 8'h00)      begin miscompares++; $display("[TB] FAIL reset_full_rgb got=%h exp=00", rgb_f); end
    vectors++; if (hsync_f !== 1'b1)     begin miscompares++; $display("[TB] FAIL reset_full_hsync got=%b exp=1", hsync_f); end
    vectors++; if (vsync_f !== 1'b1)     begin miscompares++; $display("[TB] FAIL reset_full_vsync got=%b exp=1", vsync_f); end
    vectors++; if (frame_end_f !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full_fend got=%b exp=0", frame_end_f); end
    vectors++; if (rd_addr_s !== '0)     begin miscompares++; $display("[TB] FAIL reset_small_addr got=%0d exp=0", rd_addr_s); end
    vectors++; if (rgb_s !== 8'h00)      begin miscompares++; $display("[TB] FAIL reset_small_rgb got=%h exp=00", rgb_s); end
    vectors++; if (hsync_s !== 1'b1)     begin miscompares++; $display("[TB] FAIL reset_small_hsync got=%b exp=1", hsync_s); end
    vectors++; if (vsync_s !== 1'b1)     begin miscompares++; $display("[TB] FAIL reset_small_vsync got=%b exp=1", vsync_s); end
    vectors++; if (frame_end_s !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_small_fend got=%b exp=0", frame_end_s); end
  endtask

  // Full-size geometry: first 13 lines, RAM[a] = a[7:0]
  task automatic test_full_lines();
    int k;
    int hs_low;
    for (int i = 0; i < IMG_SIZE; i++) mem[i] = 8'(i);
    @(negedge pclk);
    rst_full = 1'b0;
    k = 0;
    hs_low = 0;
    repeat (13 * 800 + 4) begin
      @(posedge pclk);
      k++;
      @(negedge pclk);
      vectors++; if (rd_addr_f !== ADDR_W'(m_addr(G_FULL, k - 1))) begin miscompares++; $display("[TB] FAIL full_addr k=%0d got=%0d exp=%0d", k, rd_addr_f, m_addr(G_FULL, k - 1)); end
      vectors++; if (rgb_f !== m_rgb(G_FULL, k - 2, 1'b0)) begin miscompares++; $display("[TB] FAIL full_rgb k=%0d got=%h exp=%h", k, rgb_f, m_rgb(G_FULL, k - 2, 1'b0)); end
      vectors++; if (hsync_f !== m_hsync(G_FULL, k - 2)) begin miscompares++; $display("[TB] FAIL full_hsync k=%0d got=%b exp=%b", k, hsync_f, m_hsync(G_FULL, k - 2)); end
      vectors++; if (vsync_f !== m_vsync(G_FULL, k - 2)) begin miscompares++; $display("[TB] FAIL full_vsync k=%0d got=%b exp=%b", k, vsync_f, m_vsync(G_FULL, k - 2)); end
      vectors++; if (frame_end_f !== m_fend(G_FULL, k - 1)) begin miscompares++; $display("[TB] FAIL full_fend k=%0d got=%b exp=%b", k, frame_end_f, m_fend(G_FULL, k - 1)); end
      if (!hsync_f) hs_low++;
      if (k - 1 == 4 * 800) begin
        vectors++; if (rd_addr_f !== 15'd160) begin miscompares++; $display("[TB] FAIL line4_start got=%0d exp=160", rd_addr_f); end
      end
    end
    vectors++; if (hs_low != 13 * 96) begin miscompares++; $display("[TB] FAIL full_hsync_low_count got=%0d exp=%0d", hs_low, 13 * 96); end
    rst_full = 1'b1;
  endtask

  // Reduced geometry: two whole frames with random RAM contents
  task automatic test_small_frames();
    int k;
    int fe_count;
    int last_fe;
    int vs_low;
    for (int i = 0; i < IMG_SIZE; i++) mem[i] = 8'($urandom);
    @(negedge pclk);
    rst_small = 1'b0;
    k = 0;
    fe_count = 0;
    last_fe = -1;
    vs_low = 0;
    repeat (2 * 4400 + 10) begin
      @(posedge pclk);
      k++;
      @(negedge pclk);
      vectors++; if (rd_addr_s !== ADDR_W'(m_addr(G_SMALL, k - 1))) begin miscompares++; $display("[TB] FAIL small_addr k=%0d got=%0d exp=%0d", k, rd_addr_s, m_addr(G_SMALL, k - 1)); end
      vectors++; if (rgb_s !== m_rgb(G_SMALL, k - 2, 1'b0)) begin miscompares++; $display("[TB] FAIL small_rgb k=%0d got=%h exp=%h", k, rgb_s, m_rgb(G_SMALL, k - 2, 1'b0)); end
      vectors++; if (hsync_s !== m_hsync(G_SMALL, k - 2)) begin miscompares++; $display("[TB] FAIL small_hsync k=%0d got=%b exp=%b", k, hsync_s, m_hsync(G_SMALL, k - 2)); end
      vectors++; if (vsync_s !== m_vsync(G_SMALL, k - 2)) begin miscompares++; $display("[TB] FAIL small_vsync k=%0d got=%b exp=%b", k, vsync_s, m_vsync(G_SMALL, k - 2)); end
      vectors++; if (frame_end_s !== m_fend(G_SMALL, k - 1)) begin miscompares++; $display("[TB] FAIL small_fend k=%0d got=%b exp=%b", k, frame_end_s, m_fend(G_SMALL, k - 1)); end
      if (!vsync_s && k >= 2 && k - 2 < 4400) vs_low++;
      if (frame_end_s === 1'b1) begin
        fe_count++;
        vectors++; if (rd_addr_s !== 15'd127) begin miscompares++; $display("[TB] FAIL fend_addr k=%0d got=%0d exp=127", k, rd_addr_s); end
        if (last_fe >= 0) begin
          vectors++; if (k - last_fe != 4400) begin miscompares++; $display("[TB] FAIL frame_period got=%0d exp=4400", k - last_fe); end
        end
        last_fe = k;
      end
    end
    vectors++; if (fe_count != 2) begin miscompares++; $display("[TB] FAIL fend_count got=%0d exp=2", fe_count); end
    vectors++; if (vs_low != 2 * 80) begin miscompares++; $display("[TB] FAIL vsync_low_count got=%0d exp=160", vs_low); end
    rst_small = 1'b1;
  endtask

  // RAM data forced to FF: only the image area may show it, blanking stays black
  task automatic test_blanking();
    int k;
    @(negedge pclk);
    rst_small = 1'b1;
    force_ff = 1'b1;
    @(negedge pclk);
    rst_small = 1'b0;
    k = 0;
    repeat (4400 + 4) begin
      @(posedge pclk);
      k++;
      @(negedge pclk);
      vectors++; if (rgb_s !== m_rgb(G_SMALL, k - 2, 1'b1)) begin miscompares++; $display("[TB] FAIL blank_rgb k=%0d got=%h exp=%h", k, rgb_s, m_rgb(G_SMALL, k - 2, 1'b1)); end
    end
    rst_small = 1'b1;
    force_ff = 1'b0;
  endtask

  // Asynchronous reset mid-frame at a fixed and at random raster positions
  task automatic test_reset_midframe();
    int p;
    int k;
    for (int t = 0; t < 3; t++) begin
      p = (t == 0) ? (20 * 80 + 30) : int'($urandom_range(54, 1)) * 80 + int'($urandom_range(79, 0));
      @(negedge pclk);
      rst_small = 1'b0;
      repeat (p) @(posedge pclk);
      @(negedge pclk);
      vectors++; if (rd_addr_s !== ADDR_W'(m_addr(G_SMALL, p - 1))) begin miscompares++; $display("[TB] FAIL pre_reset_addr p=%0d got=%0d exp=%0d", p, rd_addr_s, m_addr(G_SMALL, p - 1)); end
      vectors++; if (hsync_s !== m_hsync(G_SMALL, p - 2)) begin miscompares++; $display("[TB] FAIL pre_reset_hsync p=%0d got=%b exp=%b", p, hsync_s, m_hsync(G_SMALL, p - 2)); end
      rst_small = 1'b1;
      #1;
      vectors++; if (rd_addr_s !== '0)     begin miscompares++; $display("[TB] FAIL mid_reset_addr p=%0d got=%0d exp=0", p, rd_addr_s); end
      vectors++; if (rgb_s !== 8'h00)      begin miscompares++; $display("[TB] FAIL mid_reset_rgb p=%0d got=%h exp=00", p, rgb_s); end
      vectors++; if (hsync_s !== 1'b1)     begin miscompares++; $display("[TB] FAIL mid_reset_hsync p=%0d got=%b exp=1", p, hsync_s); end
      vectors++; if (vsync_s !== 1'b1)     begin miscompares++; $display("[TB] FAIL mid_reset_vsync p=%0d got=%b exp=1", p, vsync_s); end
      vectors++; if (frame_end_s !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_fend p=%0d got=%b exp=0", p, frame_end_s); end
      @(negedge pclk);
      rst_small = 1'b0;
      k = 0;
      repeat (400) begin
        @(posedge pclk);
        k++;
        @(negedge pclk);
        vectors++; if (rd_addr_s !== ADDR_W'(m_addr(G_SMALL, k - 1))) begin miscompares++; $display("[TB] FAIL restart_addr k=%0d got=%0d exp=%0d", k, rd_addr_s, m_addr(G_SMALL, k - 1)); end
        vectors++; if (rgb_s !== m_rgb(G_SMALL, k - 2, 1'b0)) begin miscompares++; $display("[TB] FAIL restart_rgb k=%0d got=%h exp=%h", k, rgb_s, m_rgb(G_SMALL, k - 2, 1'b0)); end
        vectors++; if (hsync_s !== m_hsync(G_SMALL, k - 2)) begin miscompares++; $display("[TB] FAIL restart_hsync k=%0d got=%b exp=%b", k, hsync_s, m_hsync(G_SMALL, k - 2)); end
        vectors++; if (vsync_s !== m_vsync(G_SMALL, k - 2)) begin miscompares++; $display("[TB] FAIL restart_vsync k=%0d got=%b exp=%b", k, vsync_s, m_vsync(G_SMALL, k - 2)); end
      end
      rst_small = 1'b1;
    end
  endtask

  initial begin
    rst_full  = 1'b0;
    rst_small = 1'b0;
    force_ff  = 1'b0;
    for (int i = 0; i < IMG_SIZE; i++) mem[i] = 8'($urandom);
    test_reset();
    test_full_lines();
    test_small_frames();
    test_blanking();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
